peasant_mult_seq: RTL and testbench
===================================

Name: peasant_mult_seq

Overview:
- Parametrised iterative shift-add ("peasant") multiplier, N-bit multiplicand by M-bit multiplier, (N+M)-bit product.
- Adds signed/unsigned mode per operation, a start/ready input handshake and a valid/ready result handshake.
- Early-terminates once the remaining multiplier bits are zero.
- Used by datapath blocks in the bai2 designs that need a small-area multiply.

Parameters:
- N, 16, multiplicand width (>=2)
- M, 16, multiplier width (>=2)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  request; accepted when start_i & ready_o
- sign_i  in  1  1 = operands two's complement, 0 = unsigned; sampled at accept
- data0_i  in  M  multiplier; sampled at accept
- data1_i  in  N  multiplicand; sampled at accept
- ready_o  out  1  core idle, can accept start
- busy_o  out  1  computation in progress
- valid_o  out  1  y_o holds a new result
- res_ready_i  in  1  consumer takes result when valid_o & res_ready_i
- y_o  out  N+M  product, signed or unsigned per sign_i of that operation

Behaviour:
- Clocking and reset
  - Single clock clk_i.
  - Reset is synchronous and active-high on rst_i.
  - rst_i high at an edge forces: state IDLE, ready_o=1, busy_o=0, valid_o=0, y_o=0, internal a/b/acc/neg=0.
  - Reset wins over every other event, including mid-RUN and DONE; any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE (ready_o=1, busy_o=0, valid_o=0)
  - On start_i=1: load operands and go to RUN.
  - a = |data0_i| (M bits unsigned).
  - b = |data1_i| zero-extended to N+M.
  - acc = 0.
  - neg = sign_i & (data0_i[M-1] ^ data1_i[N-1]).
  - When sign_i=0, the magnitudes are the raw values.
  - Most-negative operand: its magnitude 2^(W-1) fits in W unsigned bits; no special case.
- RUN (ready_o=0, busy_o=1), one multiplier bit per cycle
  - acc_n = acc + (a[0] ? b : 0); a <= a>>1; b <= b<<1; acc <= acc_n.
  - If (a>>1)==0, or a==0 on the first RUN cycle:
    - go to DONE;
    - y_o <= neg ? -acc_n : acc_n (mod 2^(N+M));
    - valid_o <= 1.
  - start_i is ignored in RUN and DONE.
- Latency
  - k = max(1, index of highest set bit of |data0_i| + 1) RUN cycles.
  - valid_o rises k edges after the accept edge.
  - Range: 1 (multiplier 0 or 1) to M (MSB of magnitude set).
- DONE (ready_o=0, busy_o=0, valid_o=1)
  - y_o stable.
  - On res_ready_i=1: go to IDLE, valid_o<=0, ready_o<=1.
  - Minimum one IDLE cycle between operations.
- Result register
  - y_o holds its last value after consumption and changes only when the next result is loaded (or on reset).
- Arithmetic
  - No overflow is possible: the full N+M product is always representable for both modes.
  - The -2^(N-1) * -2^(M-1) corner gives +2^(N+M-2).

Optional Feature:
- Macro: PEASANT_MAC_EN.
- Defined:
  - Adds input port mac_i (1 bit), sampled at accept.
  - With mac_i=1, the final load is y_o <= y_o + signed_product (mod 2^(N+M)) instead of replacement.
  - Latency unchanged; reset still clears y_o to 0.
- Not defined: port absent; y_o always replaced with the product.

Test Plan:
- Reset mid-RUN: start 0xFFFF*0xFFFF unsigned, assert rst_i after 5 RUN cycles -> next edge ready_o=1, busy_o=0, valid_o=0, y_o=0; no valid_o pulse follows.
- Unsigned: sign_i=0, data0_i=11, data1_i=13 -> valid_o 4 cycles after accept, y_o=143; hold res_ready_i=0 for 3 cycles -> y_o and valid_o stable; res_ready_i=1 -> IDLE next edge.
- Early termination / extremes: data0_i=0, data1_i=0xFFFF -> latency 1, y_o=0. data0_i=0xFFFF, data1_i=0xFFFF, unsigned -> latency 16, y_o=0xFFFE0001.
- Signed: sign_i=1, data0_i=-3 (0xFFFD), data1_i=7 -> latency 2, y_o=-21 (0xFFFFFFEB). data0_i=0x8000, data1_i=0x8000 -> latency 16, y_o=0x40000000.
- Handshake: start_i held high during RUN/DONE -> no second accept. A second operation is accepted only once ready_o=1, and yields its own correct product.
- PEASANT_MAC_EN: 5*6 (mac_i=0) then 2*-4 signed (mac_i=1) -> y_o=30 then 22. Without the macro, the same sequence gives 30 then -8.

Source files
------------

// File: rtl/peasant_mult_seq_if.sv
// Operand/result bundle for peasant_mult_seq; slave is the multiplier, master the requester.
// Defining PEASANT_MAC_EN adds mac_i (accumulate into the previous result).
interface peasant_mult_seq_if #(
  parameter int N = 16,
  parameter int M = 16
);
  logic             start_i;
  logic             sign_i;
  logic [M-1:0]     data0_i;
  logic [N-1:0]     data1_i;
  logic             res_ready_i;
`ifdef PEASANT_MAC_EN
  logic             mac_i;
`endif
  logic             ready_o;
  logic             busy_o;
  logic             valid_o;
  logic [N+M-1:0]   y_o;

  modport master (
`ifdef PEASANT_MAC_EN
    output mac_i,
`endif
    output start_i, sign_i, data0_i, data1_i, res_ready_i,
    input  ready_o, busy_o, valid_o, y_o
  );

  modport slave (
`ifdef PEASANT_MAC_EN
    input  mac_i,
`endif
    input  start_i, sign_i, data0_i, data1_i, res_ready_i,
    output ready_o, busy_o, valid_o, y_o
  );
endinterface

// File: rtl/peasant_mult_seq.sv
// Shift-add multiplier, one multiplier bit per cycle with early exit; 1..M cycles after accept; result held until res_ready_i.
// Start accepted only while ready_o; PEASANT_MAC_EN makes mac_i=1 accumulate into y_o instead of replacing it.
module peasant_mult_seq #(
  parameter int N = 16,
  parameter int M = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  peasant_mult_seq_if.slave  bus
);
  localparam int W = N + M;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q;
  logic [M-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   acc_q;
  logic [W-1:0]   y_q;
  logic           neg_q;
  logic           ready_q;
  logic           busy_q;
  logic           valid_q;
`ifdef PEASANT_MAC_EN
  logic           mac_q;
`endif

  logic [M-1:0]   mag0_d;
  logic [N-1:0]   mag1_d;
  logic           neg_d;
  logic [W-1:0]   acc_d;
  logic [W-1:0]   prod_d;
  logic [W-1:0]   y_d;
  logic           last_d;

  always_comb begin
    mag0_d = (bus.sign_i && bus.data0_i[M-1]) ? -bus.data0_i : bus.data0_i;
    mag1_d = (bus.sign_i && bus.data1_i[N-1]) ? -bus.data1_i : bus.data1_i;
    neg_d  = bus.sign_i & (bus.data0_i[M-1] ^ bus.data1_i[N-1]);
    acc_d  = acc_q + (a_q[0] ? b_q : '0);
    prod_d = neg_q ? -acc_d : acc_d;
    // Also covers a zero multiplier on the first RUN cycle.
    last_d = ((a_q >> 1) == '0);
`ifdef PEASANT_MAC_EN
    y_d    = mac_q ? (y_q + prod_d) : prod_d;
`else
    y_d    = prod_d;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      y_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
`ifdef PEASANT_MAC_EN
      mac_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            a_q     <= mag0_d;
            b_q     <= {{M{1'b0}}, mag1_d};
            acc_q   <= '0;
            neg_q   <= neg_d;
`ifdef PEASANT_MAC_EN
            mac_q   <= bus.mac_i;
`endif
            state_q <= RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q << 1;
          acc_q <= acc_d;
          if (last_d) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            y_q     <= y_d;
          end
        end
        DONE: begin
          if (bus.res_ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.busy_o  = busy_q;
  assign bus.valid_o = valid_q;
  assign bus.y_o     = y_q;

  a_flags_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
    !(busy_q && valid_q) && !(ready_q && (busy_q || valid_q)));
  a_ready_is_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    ready_q == (state_q == IDLE));
endmodule

// File: tb/tb_peasant_mult_seq.sv
// Randomised and directed bench for peasant_mult_seq against an arithmetic reference model.
module tb_peasant_mult_seq;
  localparam int N = 16;
  localparam int M = 16;
  localparam int W = N + M;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mac_drv = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [W-1:0] y_model = '0;

  always #5 clk = ~clk;

  peasant_mult_seq_if #(.N(N), .M(M)) bus ();
  peasant_mult_seq #(.N(N), .M(M)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

`ifdef PEASANT_MAC_EN
  assign bus.mac_i = mac_drv;
`endif

  function automatic logic [W-1:0] ref_prod(input logic s, input logic [M-1:0] d0, input logic [N-1:0] d1);
    longint p;
    longint u0;
    longint u1;
    u0 = longint'(d0);
    u1 = longint'(d1);
    if (s) p = longint'($signed(d0)) * longint'($signed(d1));
    else   p = u0 * u1;
    return p[W-1:0];
  endfunction

  function automatic int ref_lat(input logic s, input logic [M-1:0] d0);
    int mag;
    int k;
    mag = (s && d0[M-1]) ? -int'($signed(d0)) : int'(d0);
    k = 0;
    while (mag > 0) begin
      mag = mag >> 1;
      k++;
    end
    return (k == 0) ? 1 : k;
  endfunction

  // Expected y_o after the next operation, honouring accumulate mode when built in.
  function automatic logic [W-1:0] ref_next(input logic s, input logic [M-1:0] d0, input logic [N-1:0] d1, input logic mac);
    logic use_mac;
    use_mac = mac;
`ifndef PEASANT_MAC_EN
    use_mac = 1'b0;
`endif
    return use_mac ? (y_model + ref_prod(s, d0, d1)) : ref_prod(s, d0, d1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic s, input logic [M-1:0] d0, input logic [N-1:0] d1,
                        output int lat, output logic [W-1:0] y);
    int guard;
    guard = 0;
    while (!bus.ready_o && guard < 50) begin
      tick();
      guard++;
    end
    bus.sign_i  = s;
    bus.data0_i = d0;
    bus.data1_i = d1;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    lat = -1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (bus.valid_o) begin
        lat = c;
        break;
      end
    end
    y = bus.y_o;
  endtask

  task automatic consume();
    bus.res_ready_i = 1'b1;
    tick();
    bus.res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    logic seen;
    rst = 1'b1;
    tick();
    tick();
    total_cnt++; if (bus.ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.ready_o); else pass_cnt++;
    total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy_o); else pass_cnt++;
    total_cnt++; if (bus.valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.valid_o); else pass_cnt++;
    total_cnt++; if (bus.y_o !== '0) $display("FAIL reset_y got %h want 0", bus.y_o); else pass_cnt++;
    rst = 1'b0;
    tick();
    bus.sign_i  = 1'b0;
    bus.data0_i = 16'hFFFF;
    bus.data1_i = 16'hFFFF;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    repeat (5) tick();
    total_cnt++; if (bus.busy_o !== 1'b1) $display("FAIL midrun_busy got %b want 1", bus.busy_o); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (bus.ready_o !== 1'b1) $display("FAIL midrst_ready got %b want 1", bus.ready_o); else pass_cnt++;
    total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL midrst_busy got %b want 0", bus.busy_o); else pass_cnt++;
    total_cnt++; if (bus.valid_o !== 1'b0) $display("FAIL midrst_valid got %b want 0", bus.valid_o); else pass_cnt++;
    total_cnt++; if (bus.y_o !== '0) $display("FAIL midrst_y got %h want 0", bus.y_o); else pass_cnt++;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (bus.valid_o) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL midrst_no_valid got %b want 0", seen); else pass_cnt++;
    y_model = '0;
  endtask

  task automatic test_unsigned();
    int lat;
    logic [W-1:0] y;
    mac_drv = 1'b0;
    run_op(1'b0, 16'd11, 16'd13, lat, y);
    total_cnt++; if (lat != 4) $display("FAIL uns_lat got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (y !== 32'd143) $display("FAIL uns_y got %h want %h", y, 32'd143); else pass_cnt++;
    total_cnt++; if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0)
      $display("FAIL uns_done_flags got ready=%b busy=%b want 0 0", bus.ready_o, bus.busy_o); else pass_cnt++;
    repeat (3) begin
      tick();
      total_cnt++; if (bus.valid_o !== 1'b1 || bus.y_o !== 32'd143)
        $display("FAIL uns_hold got valid=%b y=%h want 1 %h", bus.valid_o, bus.y_o, 32'd143); else pass_cnt++;
    end
    consume();
    total_cnt++; if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0)
      $display("FAIL uns_consume got ready=%b valid=%b want 1 0", bus.ready_o, bus.valid_o); else pass_cnt++;
    total_cnt++; if (bus.y_o !== 32'd143) $display("FAIL uns_y_kept got %h want %h", bus.y_o, 32'd143); else pass_cnt++;
    y_model = 32'd143;
  endtask

  task automatic test_extremes();
    int lat;
    logic [W-1:0] y;
    mac_drv = 1'b0;
    run_op(1'b0, 16'h0000, 16'hFFFF, lat, y);
    total_cnt++; if (lat != 1) $display("FAIL zero_lat got %0d want 1", lat); else pass_cnt++;
    total_cnt++; if (y !== 32'h0) $display("FAIL zero_y got %h want 0", y); else pass_cnt++;
    consume();
    run_op(1'b0, 16'hFFFF, 16'hFFFF, lat, y);
    total_cnt++; if (lat != 16) $display("FAIL max_lat got %0d want 16", lat); else pass_cnt++;
    total_cnt++; if (y !== 32'hFFFE0001) $display("FAIL max_y got %h want FFFE0001", y); else pass_cnt++;
    consume();
    y_model = 32'hFFFE0001;
  endtask

  task automatic test_signed();
    int lat;
    logic [W-1:0] y;
    mac_drv = 1'b0;
    run_op(1'b1, 16'hFFFD, 16'd7, lat, y);
    total_cnt++; if (lat != 2) $display("FAIL sgn_lat got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (y !== 32'hFFFFFFEB) $display("FAIL sgn_y got %h want FFFFFFEB", y); else pass_cnt++;
    consume();
    run_op(1'b1, 16'h8000, 16'h8000, lat, y);
    total_cnt++; if (lat != 16) $display("FAIL minneg_lat got %0d want 16", lat); else pass_cnt++;
    total_cnt++; if (y !== 32'h40000000) $display("FAIL minneg_y got %h want 40000000", y); else pass_cnt++;
    consume();
    y_model = 32'h40000000;
  endtask

  task automatic test_back_to_back();
    int lat;
    int guard;
    mac_drv = 1'b0;
    guard = 0;
    while (!bus.ready_o && guard < 50) begin
      tick();
      guard++;
    end
    bus.sign_i  = 1'b0;
    bus.data0_i = 16'd5;
    bus.data1_i = 16'd9;
    bus.start_i = 1'b1;
    tick();
    bus.data0_i = 16'd3;
    bus.data1_i = 16'd3;
    lat = -1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (bus.valid_o) begin
        lat = c;
        break;
      end
    end
    total_cnt++; if (lat != ref_lat(1'b0, 16'd5)) $display("FAIL b2b_lat1 got %0d want %0d", lat, ref_lat(1'b0, 16'd5)); else pass_cnt++;
    total_cnt++; if (bus.y_o !== ref_prod(1'b0, 16'd5, 16'd9)) $display("FAIL b2b_y1 got %h want %h", bus.y_o, ref_prod(1'b0, 16'd5, 16'd9)); else pass_cnt++;
    repeat (2) tick();
    total_cnt++; if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0 || bus.y_o !== 32'd45)
      $display("FAIL b2b_done_hold got valid=%b ready=%b y=%h want 1 0 %h", bus.valid_o, bus.ready_o, bus.y_o, 32'd45); else pass_cnt++;
    consume();
    total_cnt++; if (bus.ready_o !== 1'b1) $display("FAIL b2b_idle got ready=%b want 1", bus.ready_o); else pass_cnt++;
    tick();
    bus.start_i = 1'b0;
    total_cnt++; if (bus.busy_o !== 1'b1) $display("FAIL b2b_accept2 got busy=%b want 1", bus.busy_o); else pass_cnt++;
    lat = -1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (bus.valid_o) begin
        lat = c;
        break;
      end
    end
    total_cnt++; if (lat != ref_lat(1'b0, 16'd3)) $display("FAIL b2b_lat2 got %0d want %0d", lat, ref_lat(1'b0, 16'd3)); else pass_cnt++;
    total_cnt++; if (bus.y_o !== ref_prod(1'b0, 16'd3, 16'd3)) $display("FAIL b2b_y2 got %h want %h", bus.y_o, ref_prod(1'b0, 16'd3, 16'd3)); else pass_cnt++;
    consume();
    y_model = ref_prod(1'b0, 16'd3, 16'd3);
  endtask

  task automatic test_random();
    int lat;
    int hold;
    logic [W-1:0] y;
    logic [W-1:0] exp_y;
    logic s;
    logic [M-1:0] d0;
    logic [N-1:0] d1;
    for (int i = 0; i < 24; i++) begin
      s  = 1'($urandom_range(0, 1));
      d0 = M'($urandom);
      d1 = N'($urandom);
      if (i % 6 == 1) d0 = d0 >> $urandom_range(4, 15);
      if (i % 6 == 4) d0 = 16'h8000;
      mac_drv = 1'($urandom_range(0, 1));
      exp_y = ref_next(s, d0, d1, mac_drv);
      run_op(s, d0, d1, lat, y);
      total_cnt++; if (lat != ref_lat(s, d0)) $display("FAIL rnd_lat[%0d] got %0d want %0d", i, lat, ref_lat(s, d0)); else pass_cnt++;
      total_cnt++; if (y !== exp_y) $display("FAIL rnd_y[%0d] got %h want %h", i, y, exp_y); else pass_cnt++;
      y_model = exp_y;
      hold = $urandom_range(0, 2);
      repeat (hold) tick();
      total_cnt++; if (bus.valid_o !== 1'b1 || bus.y_o !== exp_y)
        $display("FAIL rnd_hold[%0d] got valid=%b y=%h want 1 %h", i, bus.valid_o, bus.y_o, exp_y); else pass_cnt++;
      consume();
    end
    mac_drv = 1'b0;
  endtask

  task automatic test_mac();
    int lat;
    logic [W-1:0] y;
    logic [W-1:0] exp2;
    mac_drv = 1'b0;
    run_op(1'b0, 16'd5, 16'd6, lat, y);
    total_cnt++; if (y !== 32'd30) $display("FAIL mac_first got %h want %h", y, 32'd30); else pass_cnt++;
    consume();
    y_model = 32'd30;
`ifdef PEASANT_MAC_EN
    exp2 = 32'd22;
`else
    exp2 = 32'hFFFFFFF8;
`endif
    mac_drv = 1'b1;
    run_op(1'b1, 16'd2, 16'hFFFC, lat, y);
    total_cnt++; if (lat != 2) $display("FAIL mac_lat got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (y !== exp2) $display("FAIL mac_second got %h want %h", y, exp2); else pass_cnt++;
    consume();
    mac_drv = 1'b0;
    y_model = exp2;
  endtask

  initial begin
    bus.start_i     = 1'b0;
    bus.sign_i      = 1'b0;
    bus.data0_i     = '0;
    bus.data1_i     = '0;
    bus.res_ready_i = 1'b0;
    test_reset();
    test_unsigned();
    test_extremes();
    test_signed();
    test_back_to_back();
    test_mac();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
